// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencing with one-delay-slot redirects, stall hold,
// halt on a redirect to HALT_ADDR and a sticky fault on misaligned targets.
//
// state   | meaning
// --------+------------------------------------------------------------
// FIRST   | just out of reset, PC = RESET_VECTOR, nothing delivered yet
// RUN     | fetching sequentially or following redirects
// HALTED  | PC reached HALT_ADDR; fetch stopped until reset
// FAULT   | misaligned target selected; fetch stopped until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_if_valid;
  logic        r_fault;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  logic [31:0] w_sel_pc;
  logic        w_is_halt;
  logic        w_misalign;
  logic        w_fetch;
  logic        w_pc_load;
  logic        w_pend_set;
  logic        w_pend_clr;
  logic        w_fault_set;
  logic        w_valid_clr;

  // A pending (stall-latched) redirect outranks a fresh one on the consuming edge.
  always_comb begin
    if (r_pend_valid) begin
      w_sel_pc = r_pend_target;
    end else if (redirect_valid) begin
      w_sel_pc = redirect_target;
    end else begin
      w_sel_pc = r_pc + 32'd4;
    end
  end

  assign w_is_halt  = (w_sel_pc == HALT_ADDR);
  assign w_misalign = (w_sel_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_pc_load   = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_fault_set = 1'b0;
    w_valid_clr = 1'b0;
    case (r_state)
      FIRST, RUN: begin
        if (stall) begin
          w_pend_set = redirect_valid;
        end else begin
          w_fetch    = 1'b1;
          w_pend_clr = 1'b1;
          if (w_is_halt) begin
            w_pc_load   = 1'b1;
            w_state_nxt = HALTED;
          end else if (w_misalign) begin
            w_fault_set = 1'b1;
            w_state_nxt = FAULT;
          end else begin
            w_pc_load   = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      HALTED, FAULT: begin
        w_valid_clr = 1'b1;
      end
      default: begin
        w_state_nxt = FIRST;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_if_instr    <= 32'd0;
      r_if_pc       <= 32'd0;
      r_if_valid    <= 1'b0;
      r_fault       <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
    end else begin
      if (w_fetch) begin
        r_if_instr <= instr_readdata;
        r_if_pc    <= r_pc;
        r_if_valid <= 1'b1;
      end else if (w_valid_clr) begin
        r_if_valid <= 1'b0;
      end
      if (w_pc_load) begin
        r_pc <= w_sel_pc;
      end
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end
      // A later redirect during the same stall simply overwrites the entry.
      if (w_pend_set) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= redirect_target;
      end else if (w_pend_clr) begin
        r_pend_valid  <= 1'b0;
      end
    end
  end

  assign instr_address = r_pc;
  assign if_instr      = r_if_instr;
  assign if_pc         = r_if_pc;
  assign if_valid      = r_if_valid;
  assign fault         = r_fault;
  assign active        = (r_state == FIRST) || (r_state == RUN);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected deliveries are queued by the stimulus
// and checked by an independent monitor; control outputs are checked inline.
module tb_instr_fetch_unit;

  localparam logic [31:0] KEY = 32'h5A5A0F0F;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        active;
  logic        fault;

  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .active          (active),
    .fault           (fault)
  );

  // Combinational instruction RAM model: content is a fixed function of the address.
  assign instr_readdata = instr_address ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc ^ KEY;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a delivery is any non-stalled, out-of-reset edge after which if_valid is high.
  initial begin
    logic st;
    logic rs;
    exp_t e;
    forever begin
      @(posedge clk);
      st = stall;
      rs = reset;
      #1;
      if (!rs && !st && if_valid) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_delivery: got if_pc %08h, required no delivery", if_pc);
        end else begin
          e = sb_q.pop_front();
          if (if_pc !== e.pc || if_instr !== e.instr) begin
            n_err++;
            $display("FAIL delivery: got pc %08h instr %08h, required pc %08h instr %08h",
                     if_pc, if_instr, e.pc, e.instr);
          end
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    step(2);
    reset = 1'b0;

    // Reset state and three free-running fetches
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    expect_fetch(32'hBFC00000);
    expect_fetch(32'hBFC00004);
    expect_fetch(32'hBFC00008);
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", instr_address, 32'hBFC00000 + 32'(4 * i));
      if (i > 0) begin
        chk("seq_if_pc_lag", if_pc, 32'hBFC00000 + 32'(4 * (i - 1)));
        chk("seq_if_valid", {31'd0, if_valid}, 32'd1);
      end
      step(1);
    end
    chk("seq_addr3", instr_address, 32'hBFC0000C);

    // Branch at 0x10 resolves while 0x14 is fetched: 0x14 is the delay slot
    expect_fetch(32'hBFC0000C);
    expect_fetch(32'hBFC00010);
    step(2);
    chk("br_pc_before", instr_address, 32'hBFC00014);
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC00040;
    expect_fetch(32'hBFC00014);
    step(1);
    redirect_valid = 1'b0;
    chk("br_pc_target", instr_address, 32'hBFC00040);
    expect_fetch(32'hBFC00040);
    step(1);
    chk("br_pc_after", instr_address, 32'hBFC00044);

    // One-cycle redirect inside a three-cycle stall
    stall = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC00080;
    step(1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("stall_addr", instr_address, 32'hBFC00044);
      chk("stall_if_pc", if_pc, 32'hBFC00040);
      step(1);
    end
    stall = 1'b0;
    expect_fetch(32'hBFC00044);
    step(1);
    chk("stall_redir_pc", instr_address, 32'hBFC00080);

    // Second redirect during the same stall overwrites the pending one
    stall = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC00200;
    step(1);
    redirect_target = 32'hBFC00300;
    step(1);
    redirect_valid = 1'b0;
    stall = 1'b0;
    expect_fetch(32'hBFC00080);
    step(1);
    chk("overwrite_pc", instr_address, 32'hBFC00300);

    // Redirect to HALT_ADDR: delay slot delivered, then fetch stops
    redirect_valid  = 1'b1;
    redirect_target = 32'h00000000;
    expect_fetch(32'hBFC00300);
    step(1);
    chk("halt_pc", instr_address, 32'h00000000);
    chk("halt_active", {31'd0, active}, 32'd0);
    chk("halt_slot_valid", {31'd0, if_valid}, 32'd1);
    redirect_target = 32'hBFC00100;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      step(1);
      chk("halt_hold_pc", instr_address, 32'h00000000);
      chk("halt_hold_valid", {31'd0, if_valid}, 32'd0);
      chk("halt_hold_active", {31'd0, active}, 32'd0);
    end
    redirect_valid = 1'b0;
    stall = 1'b0;

    // Reset with a redirect pending mid-stall clears the pending entry
    reset = 1'b1;
    #1;
    chk("rst2_pc", instr_address, 32'hBFC00000);
    chk("rst2_active", {31'd0, active}, 32'd1);
    step(1);
    reset = 1'b0;
    stall = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC00500;
    step(1);
    reset = 1'b1;
    #1;
    chk("rst_mid_stall_valid", {31'd0, if_valid}, 32'd0);
    step(1);
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    expect_fetch(32'hBFC00000);
    step(1);
    chk("pend_cleared_pc", instr_address, 32'hBFC00004);

    // Misaligned target: fault, PC not loaded, current fetch still delivered
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC00042;
    expect_fetch(32'hBFC00004);
    step(1);
    redirect_valid = 1'b0;
    chk("fault_flag", {31'd0, fault}, 32'd1);
    chk("fault_active", {31'd0, active}, 32'd0);
    chk("fault_pc_held", instr_address, 32'hBFC00004);
    step(1);
    chk("fault_valid_drop", {31'd0, if_valid}, 32'd0);
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    reset = 1'b1;
    #1;
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    chk("fault_rst_pc", instr_address, 32'hBFC00000);
    step(1);
    reset = 1'b0;
    expect_fetch(32'hBFC00000);
    step(1);
    chk("refetch_pc", instr_address, 32'hBFC00004);

    // PC wrap from 0xFFFFFFFC lands on HALT_ADDR
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFFFFFC;
    expect_fetch(32'hBFC00004);
    step(1);
    redirect_valid = 1'b0;
    chk("wrap_pc_top", instr_address, 32'hFFFFFFFC);
    expect_fetch(32'hFFFFFFFC);
    step(1);
    chk("wrap_pc_zero", instr_address, 32'h00000000);
    chk("wrap_active", {31'd0, active}, 32'd0);
    chk("wrap_slot_pc", if_pc, 32'hFFFFFFFC);
    step(2);
    chk("wrap_valid_drop", {31'd0, if_valid}, 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
